hardware_divider: RTL and testbench
===================================

HARDWARE_DIVIDER -- requirements
Module: hardware_divider

Interface
REQ-001 SHALL have parameter DIVIDEND_W, default 8, dividend and quotient width in bits.
REQ-002 SHALL have parameter DIVISOR_W, default 4, divisor and remainder width in bits.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  request a new division; sampled on rising clk.
REQ-007 SHALL have port dividend  input  DIVIDEND_W  unsigned dividend; sampled only when start is accepted.
REQ-008 SHALL have port divisor  input  DIVISOR_W  unsigned divisor; sampled only when start is accepted.
REQ-009 SHALL have port quotient  output  DIVIDEND_W  registered unsigned quotient.
REQ-010 SHALL have port remainder  output  DIVISOR_W  registered unsigned remainder.
REQ-011 SHALL have port busy  output  1  high while a division is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse marking that results are valid.
REQ-013 SHALL have port div_by_zero  output  1  registered flag for the last completed division: set when its divisor was 0.

Function
REQ-014 SHALL implement an FSM with three states: IDLE, RUN and ZERO.
REQ-015 SHALL accept start only in IDLE; start while busy=1 SHALL be ignored and SHALL NOT alter the latched operands.
REQ-016 On acceptance with divisor!=0 (edge E0), the block SHALL latch both operands, clear the partial remainder and iteration counter, enter RUN, and set busy=1.
REQ-017 RUN SHALL perform restoring division MSB-first, one quotient bit per edge, over exactly DIVIDEND_W edges (E1..E8 at defaults).
REQ-018 Each RUN step SHALL shift the next dividend bit into a (DIVISOR_W+1)-bit partial remainder, then compare it against the divisor.
REQ-019 In each RUN step, if partial remainder >= divisor, the divisor SHALL be subtracted and the quotient bit set to 1; otherwise the quotient bit SHALL be 0.
REQ-020 At edge E(DIVIDEND_W), the block SHALL update quotient and remainder, clear div_by_zero, set busy=0 and done=1, and return to IDLE.
REQ-021 Latency SHALL be DIVIDEND_W cycles from the start sample to done (8 cycles at defaults).
REQ-022 Results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor.
REQ-023 On acceptance with divisor==0, the block SHALL enter ZERO with busy=1; at the next edge it SHALL set quotient to all ones, remainder=0, div_by_zero=1, busy=0, done=1, and return to IDLE.
REQ-024 done SHALL be high for exactly one cycle per accepted start.
REQ-025 start asserted during the done cycle SHALL be accepted, since the FSM is in IDLE; this gives back-to-back operation with no idle gap.
REQ-026 quotient, remainder and div_by_zero SHALL hold their values from completion until the next completion; they SHALL NOT change during RUN.
REQ-027 Intermediate quotient and partial-remainder state SHALL be internal only.

Reset
REQ-028 Asserting rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and clear all internal registers.
REQ-029 Reset asserted mid-RUN SHALL abandon the division, produce no done pulse, and leave the block ready to accept start on the first edge after rst_n deasserts.

Verification
REQ-030 Bench SHALL cover: 225/15 -> after 8 cycles done=1, quotient=15, remainder=0, div_by_zero=0.
REQ-031 Bench SHALL cover: 100/7 -> quotient=14, remainder=2; then 255/1 -> quotient=255, remainder=0; then 3/9 -> quotient=0, remainder=3.
REQ-032 Bench SHALL cover: 13/0 -> done one cycle after the start sample, quotient=255, remainder=0, div_by_zero=1; then 20/4 -> quotient=5, remainder=0, div_by_zero=0.
REQ-033 Bench SHALL cover: start 200/9 followed by start 50/5 issued at cycle 3 -> second request ignored; result is quotient=22, remainder=2.
REQ-034 Bench SHALL cover: 99/5 started, reset asserted at cycle 4 -> all outputs 0 and no done pulse; new 99/5 after reset -> quotient=19, remainder=4.
REQ-035 Bench SHALL cover: start held high through the done cycle -> back-to-back results, with exactly one done pulse per division.

Source files
------------

// File: rtl/hardware_divider.sv
// rtl/hardware_divider.sv - multi-cycle restoring unsigned divider
// One quotient bit per clock, MSB first; a zero divisor is flagged after a single cycle.
module hardware_divider #(
   parameter int DIVIDEND_W = 8,
   parameter int DIVISOR_W  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  busy,
   output logic                  done,
   output logic                  div_by_zero
);

   localparam int CNT_W = $clog2(DIVIDEND_W + 1);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_ZERO = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [DIVIDEND_W-1:0]   work_q, work_d;
   logic [DIVISOR_W-1:0]    prem_q, prem_d;
   logic [DIVISOR_W-1:0]    dsr_q, dsr_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [DIVIDEND_W-1:0]   quo_q, quo_d;
   logic [DIVISOR_W-1:0]    rem_q, rem_d;
   logic                    dbz_q, dbz_d;
   logic                    done_q, done_d;

   logic [DIVISOR_W:0]      shifted;
   logic                    ge;
   logic [DIVISOR_W-1:0]    step_prem;
   logic [DIVIDEND_W-1:0]   step_work;

   // work_q holds the dividend bits still to consume in its top and the
   // quotient bits already produced in its bottom; after the last step it is
   // the whole quotient. The kept remainder is always below the divisor, so
   // the subtraction only needs DIVISOR_W bits.
   always_comb begin
      shifted   = {prem_q, work_q[DIVIDEND_W-1]};
      ge        = (shifted >= {1'b0, dsr_q});
      step_prem = ge ? (shifted[DIVISOR_W-1:0] - dsr_q) : shifted[DIVISOR_W-1:0];
      step_work = {work_q[DIVIDEND_W-2:0], ge};
   end

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      prem_d  = prem_q;
      dsr_d   = dsr_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (divisor == '0) begin
                  state_d = S_ZERO;
               end else begin
                  state_d = S_RUN;
                  work_d  = dividend;
                  dsr_d   = divisor;
                  prem_d  = '0;
                  cnt_d   = '0;
               end
            end
         end
         S_RUN: begin
            work_d = step_work;
            prem_d = step_prem;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) begin
               state_d = S_IDLE;
               quo_d   = step_work;
               rem_d   = step_prem;
               dbz_d   = 1'b0;
               done_d  = 1'b1;
            end
         end
         S_ZERO: begin
            state_d = S_IDLE;
            quo_d   = '1;
            rem_d   = '0;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         work_q  <= '0;
         prem_q  <= '0;
         dsr_q   <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         prem_q  <= prem_d;
         dsr_q   <= dsr_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         done_q  <= done_d;
      end
   end

   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
   assign done        = done_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_hardware_divider.sv
// tb/tb_hardware_divider.sv - self-checking bench for hardware_divider
// Arithmetic reference model checked every cycle, plus directed literal cases.
module tb_hardware_divider;

   localparam int DW = 8;
   localparam int DS = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [DW-1:0] dividend = '0;
   logic [DS-1:0] divisor = '0;
   logic [DW-1:0] quotient;
   logic [DS-1:0] remainder;
   logic          busy;
   logic          done;
   logic          div_by_zero;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   hardware_divider #(.DIVIDEND_W(DW), .DIVISOR_W(DS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: cycles left until done, and the results to publish then.
   int m_left = 0;
   int pend_q = 0, pend_r = 0, pend_z = 0;
   int exp_q = 0, exp_r = 0, exp_z = 0, exp_done = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left   <= 0;
         exp_q    <= 0;
         exp_r    <= 0;
         exp_z    <= 0;
         exp_done <= 0;
      end else if (m_left > 0) begin
         m_left   <= m_left - 1;
         exp_done <= (m_left == 1) ? 1 : 0;
         if (m_left == 1) begin
            exp_q <= pend_q;
            exp_r <= pend_r;
            exp_z <= pend_z;
         end
      end else begin
         exp_done <= 0;
         if (start) begin
            if (divisor == 0) begin
               m_left <= 1;
               pend_q <= (1 << DW) - 1;
               pend_r <= 0;
               pend_z <= 1;
            end else begin
               m_left <= DW;
               pend_q <= int'(dividend) / int'(divisor);
               pend_r <= int'(dividend) % int'(divisor);
               pend_z <= 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("done",        int'(done),        exp_done);
         chk("busy",        int'(busy),        (m_left > 0) ? 1 : 0);
         chk("quotient",    int'(quotient),    exp_q);
         chk("remainder",   int'(remainder),   exp_r);
         chk("div_by_zero", int'(div_by_zero), exp_z);
      end
   end

   // Called 1 time unit after a rising edge; leaves at the same phase in the done cycle.
   task automatic run_div(input string tag, input int a, input int b,
                          input int eq, input int er, input int ez, input int elat);
      int lat;
      lat = 0;
      dividend = DW'(a);
      divisor  = DS'(b);
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = i;
            break;
         end
      end
      chk({tag, "_latency"}, lat, elat);
      chk({tag, "_q"}, int'(quotient), eq);
      chk({tag, "_r"}, int'(remainder), er);
      chk({tag, "_z"}, int'(div_by_zero), ez);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int dcount;
      int prev_done;
      #12;
      chk("reset_q", int'(quotient), 0);
      chk("reset_r", int'(remainder), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_z", int'(div_by_zero), 0);
      @(posedge clk); #1;
      rst_n  = 1'b1;
      chk_en = 1'b1;
      @(posedge clk); #1;

      run_div("d225_15", 225, 15, 15, 0, 0, 8);
      run_div("d100_7", 100, 7, 14, 2, 0, 8);
      run_div("d255_1", 255, 1, 255, 0, 0, 8);
      run_div("d3_9", 3, 9, 0, 3, 0, 8);
      run_div("d13_0", 13, 0, 255, 0, 1, 1);
      run_div("d20_4", 20, 4, 5, 0, 0, 8);

      // A second request while busy must be dropped.
      dividend = 8'd200; divisor = 4'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (i == 2) begin
            dividend = 8'd50; divisor = 4'd5; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            lat = i;
            break;
         end
      end
      chk("ign_latency", lat, 8);
      chk("ign_q", int'(quotient), 22);
      chk("ign_r", int'(remainder), 2);
      @(posedge clk); #1;

      // Reset in the middle of a division.
      dividend = 8'd99; divisor = 4'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      chk("rst_mid_q", int'(quotient), 0);
      chk("rst_mid_r", int'(remainder), 0);
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_done", int'(done), 0);
      chk("rst_mid_z", int'(div_by_zero), 0);
      dcount = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (i == 1) rst_n = 1'b1;
         dcount += int'(done);
      end
      chk("rst_no_done", dcount, 0);
      run_div("d99_5", 99, 5, 19, 4, 0, 8);
      @(posedge clk); #1;

      // start held high: back-to-back divisions, one done per result.
      dividend = 8'd77; divisor = 4'd6; start = 1'b1;
      @(posedge clk); #1;
      dcount = 0;
      prev_done = 0;
      for (int i = 1; i <= 26; i++) begin
         @(posedge clk); #1;
         if (i == 26) start = 1'b0;
         if (done) begin
            dcount++;
            chk("b2b_single_pulse", prev_done, 0);
            chk("b2b_q", int'(quotient), 12);
            chk("b2b_r", int'(remainder), 5);
         end
         prev_done = int'(done);
      end
      chk("b2b_count", dcount, 3);
      repeat (3) begin @(posedge clk); #1; end

      // Random traffic, including starts while busy and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if ($urandom_range(0, 399) == 0) begin
            rst_n = 1'b0;
         end else begin
            rst_n = 1'b1;
         end
         start    = ($urandom_range(0, 3) == 0);
         dividend = DW'($urandom_range(0, 255));
         divisor  = ($urandom_range(0, 7) == 0) ? '0 : DS'($urandom_range(1, 15));
      end
      rst_n = 1'b1;
      start = 1'b0;
      repeat (12) begin @(posedge clk); #1; end

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
